mem_port_arbiter: RTL and testbench

Shares the core's single unified memory port between the instruction-fetch requester and the load/store (data) requester. It sits between the fetch stage, the memory stage and the memory bus. At most one transaction is outstanding at a time. Data accesses have priority, and a starvation counter guarantees forward progress for instruction fetch.

---
 rtl/mem_port_arbiter_pkg.sv | 17 +
 rtl/mem_arb_pick.sv | 38 +++
 rtl/mem_port_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified memory port arbiter.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } state_t;

   localparam logic OWN_I = 1'b0;
   localparam logic OWN_D = 1'b1;

   localparam int DEF_ADDR_W     = 32;
   localparam int DEF_DATA_W     = 32;
   localparam int DEF_STARVE_MAX = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between fetch and data, with a starvation counter that
// forces a fetch win after STARVE_MAX consecutive data wins over a waiting fetch.
module mem_arb_pick
   import mem_port_arbiter_pkg::*;
#(
   parameter int STARVE_MAX = DEF_STARVE_MAX
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_req,
   input  logic d_req,
   input  logic arb,
   output logic winner
);

   logic [3:0] r_starve_cnt;
   logic       w_starved;

   assign w_starved = (r_starve_cnt == 4'(STARVE_MAX));

   always_comb begin
      winner = OWN_D;
      if (i_req && (!d_req || w_starved))
         winner = OWN_I;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_starve_cnt <= '0;
      end else if (arb && (i_req || d_req)) begin
         if (winner == OWN_I || !i_req)
            r_starve_cnt <= '0;
         else if (!w_starved)
            r_starve_cnt <= r_starve_cnt + 4'd1;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store; one transaction in flight,
// data-first arbitration with starvation protection for fetch.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int STARVE_MAX = DEF_STARVE_MAX
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_req,
   input  logic [ADDR_W-1:0]   i_addr,
   output logic                i_gnt,
   output logic                i_rvalid,
   output logic [DATA_W-1:0]   i_rdata,
   input  logic                d_req,
   input  logic                d_we,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_be,
   output logic                d_gnt,
   output logic                d_rvalid,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                m_req,
   output logic                m_we,
   output logic [ADDR_W-1:0]   m_addr,
   output logic [DATA_W-1:0]   m_wdata,
   output logic [DATA_W/8-1:0] m_be,
   input  logic                m_gnt,
   input  logic                m_rvalid,
   input  logic [DATA_W-1:0]   m_rdata,
   output logic                busy
);

   state_t                r_state;
   logic                  r_owner;
   logic                  r_m_req;
   logic                  r_m_we;
   logic [ADDR_W-1:0]     r_m_addr;
   logic [DATA_W-1:0]     r_m_wdata;
   logic [DATA_W/8-1:0]   r_m_be;

   logic                  w_arb;
   logic                  w_pending;
   logic                  w_winner;
   logic                  w_nxt_we;
   logic [ADDR_W-1:0]     w_nxt_addr;
   logic [DATA_W-1:0]     w_nxt_wdata;
   logic [DATA_W/8-1:0]   w_nxt_be;

   assign w_pending = i_req | d_req;
   assign w_arb     = (r_state == ST_IDLE) || ((r_state == ST_WAIT) && m_rvalid);

   mem_arb_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_req  (i_req),
      .d_req  (d_req),
      .arb    (w_arb),
      .winner (w_winner)
   );

   // Fetch transactions are always full-word reads.
   assign w_nxt_we    = (w_winner == OWN_D) ? d_we    : 1'b0;
   assign w_nxt_addr  = (w_winner == OWN_D) ? d_addr  : i_addr;
   assign w_nxt_wdata = (w_winner == OWN_D) ? d_wdata : '0;
   assign w_nxt_be    = (w_winner == OWN_D) ? d_be    : '1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_owner   <= OWN_D;
         r_m_req   <= 1'b0;
         r_m_we    <= 1'b0;
         r_m_addr  <= '0;
         r_m_wdata <= '0;
         r_m_be    <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_pending) begin
                  r_owner   <= w_winner;
                  r_m_req   <= 1'b1;
                  r_m_we    <= w_nxt_we;
                  r_m_addr  <= w_nxt_addr;
                  r_m_wdata <= w_nxt_wdata;
                  r_m_be    <= w_nxt_be;
                  r_state   <= ST_REQ;
               end
            end
            ST_REQ: begin
               if (m_gnt) begin
                  r_m_req <= 1'b0;
                  r_state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (m_rvalid) begin
                  if (w_pending) begin
                     r_owner   <= w_winner;
                     r_m_req   <= 1'b1;
                     r_m_we    <= w_nxt_we;
                     r_m_addr  <= w_nxt_addr;
                     r_m_wdata <= w_nxt_wdata;
                     r_m_be    <= w_nxt_be;
                     r_state   <= ST_REQ;
                  end else begin
                     r_state <= ST_IDLE;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign m_req   = r_m_req;
   assign m_we    = r_m_we;
   assign m_addr  = r_m_addr;
   assign m_wdata = r_m_wdata;
   assign m_be    = r_m_be;
   assign busy    = (r_state != ST_IDLE);

   // Responses route only by the latched owner; stray handshakes in other states are dropped.
   assign i_gnt    = (r_state == ST_REQ)  && m_gnt    && (r_owner == OWN_I);
   assign d_gnt    = (r_state == ST_REQ)  && m_gnt    && (r_owner == OWN_D);
   assign i_rvalid = (r_state == ST_WAIT) && m_rvalid && (r_owner == OWN_I);
   assign d_rvalid = (r_state == ST_WAIT) && m_rvalid && (r_owner == OWN_D);
   assign i_rdata  = i_rvalid ? m_rdata : '0;
   assign d_rdata  = d_rvalid ? m_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs change 1 ns after the rising edge,
// outputs are checked on the falling edge.
module tb_mem_port_arbiter;

   logic        clk;
   logic        rst_n;
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_gnt;
   logic        i_rvalid;
   logic [31:0] i_rdata;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [3:0]  d_be;
   logic        d_gnt;
   logic        d_rvalid;
   logic [31:0] d_rdata;
   logic        m_req;
   logic        m_we;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic [3:0]  m_be;
   logic        m_gnt;
   logic        m_rvalid;
   logic [31:0] m_rdata;
   logic        busy;

   int n_tot = 0;
   int n_bad = 0;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_req    (i_req),
      .i_addr   (i_addr),
      .i_gnt    (i_gnt),
      .i_rvalid (i_rvalid),
      .i_rdata  (i_rdata),
      .d_req    (d_req),
      .d_we     (d_we),
      .d_addr   (d_addr),
      .d_wdata  (d_wdata),
      .d_be     (d_be),
      .d_gnt    (d_gnt),
      .d_rvalid (d_rvalid),
      .d_rdata  (d_rdata),
      .m_req    (m_req),
      .m_we     (m_we),
      .m_addr   (m_addr),
      .m_wdata  (m_wdata),
      .m_be     (m_be),
      .m_gnt    (m_gnt),
      .m_rvalid (m_rvalid),
      .m_rdata  (m_rdata),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0;
      d_wdata = 0; d_be = 0; m_gnt = 0; m_rvalid = 0; m_rdata = 0;
      repeat (2) cyc();
      smp();
      chk("rst_m_req", m_req, 0);
      chk("rst_busy", busy, 0);
      chk("rst_m_addr", m_addr, 0);
      chk("rst_m_be", m_be, 0);
      chk("rst_gnt", {i_gnt, d_gnt, i_rvalid, d_rvalid}, 0);
      cyc();
      rst_n = 1'b1;

      // single fetch, minimum latency
      cyc();
      i_req = 1; i_addr = 32'h100;
      smp();
      chk("f_c0_mreq", m_req, 0);
      cyc();
      m_gnt = 1;
      smp();
      chk("f_c1_mreq", m_req, 1);
      chk("f_c1_addr", m_addr, 32'h100);
      chk("f_c1_we_be", {m_we, m_be}, 5'b0_1111);
      chk("f_c1_wdata", m_wdata, 0);
      chk("f_c1_gnt", {i_gnt, d_gnt}, 2'b10);
      cyc();
      i_req = 0; m_gnt = 0; m_rvalid = 1; m_rdata = 32'hDEADBEEF;
      smp();
      chk("f_c2_rv", {i_rvalid, d_rvalid}, 2'b10);
      chk("f_c2_irdata", i_rdata, 32'hDEADBEEF);
      chk("f_c2_drdata", d_rdata, 0);
      chk("f_c2_mreq", m_req, 0);
      cyc();
      m_rvalid = 0;
      smp();
      chk("f_c3_busy", busy, 0);

      // store
      d_req = 1; d_we = 1; d_addr = 32'h2004; d_wdata = 32'h55AA; d_be = 4'b0011;
      cyc();
      m_gnt = 1;
      smp();
      chk("st_fields", {m_req, m_we, m_be}, 6'b1_1_0011);
      chk("st_addr", m_addr, 32'h2004);
      chk("st_wdata", m_wdata, 32'h55AA);
      chk("st_gnt", {i_gnt, d_gnt}, 2'b01);
      cyc();
      d_req = 0; d_we = 0; m_gnt = 0; m_rvalid = 1; m_rdata = 32'h1234;
      smp();
      chk("st_rv", {i_rvalid, d_rvalid}, 2'b01);
      cyc();
      m_rvalid = 0;

      // contention: 4 data grants then 1 fetch grant, repeated
      i_req = 1; i_addr = 32'h1000; d_req = 1; d_addr = 32'h2000; d_be = 4'hF;
      cyc();
      for (int k = 0; k < 10; k++) begin
         m_gnt = 1; m_rvalid = 0;
         smp();
         chk("ct_mreq", m_req, 1);
         chk("ct_gnt", {i_gnt, d_gnt}, (k % 5 == 4) ? 2'b10 : 2'b01);
         chk("ct_addr", m_addr, (k % 5 == 4) ? 32'h1000 : 32'h2000);
         cyc();
         m_gnt = 0; m_rvalid = 1; m_rdata = 32'(k);
         if (k == 9) begin
            i_req = 0; d_req = 0;
         end
         smp();
         chk("ct_rv", {i_rvalid, d_rvalid}, (k % 5 == 4) ? 2'b10 : 2'b01);
         cyc();
      end
      m_rvalid = 0;
      smp();
      chk("ct_idle", busy, 0);

      // memory stall with stray rvalid in REQ and stray gnt in WAIT
      d_req = 1; d_we = 0; d_addr = 32'h300;
      cyc();
      for (int s = 0; s < 5; s++) begin
         m_rvalid = (s == 0);
         smp();
         chk("sl_req", {m_req, busy, d_gnt, d_rvalid, i_rvalid}, 5'b11000);
         chk("sl_addr", m_addr, 32'h300);
         cyc();
      end
      m_rvalid = 0; m_gnt = 1;
      smp();
      chk("sl_gnt", {i_gnt, d_gnt}, 2'b01);
      for (int s = 0; s < 2; s++) begin
         cyc();
         d_req = 0; m_gnt = (s == 1);
         smp();
         chk("sl_wait", {m_req, busy, d_gnt, d_rvalid}, 4'b0100);
         chk("sl_waddr", m_addr, 32'h300);
      end
      cyc();
      m_gnt = 0; m_rvalid = 1; m_rdata = 32'hCAFE;
      smp();
      chk("sl_rv", {d_rvalid, d_rdata}, {1'b1, 32'hCAFE});
      cyc();
      m_rvalid = 0;
      smp();
      chk("sl_idle", busy, 0);

      // reset in WAIT
      i_req = 1; i_addr = 32'h400;
      cyc();
      m_gnt = 1;
      smp();
      chk("rs_gnt", i_gnt, 1);
      cyc();
      i_req = 0; m_gnt = 0; rst_n = 0;
      smp();
      chk("rs_outs", {m_req, busy, m_addr}, 0);
      cyc();
      rst_n = 1; m_rvalid = 1; m_rdata = 32'h77;
      smp();
      chk("rs_late_rv", {i_rvalid, d_rvalid, busy}, 0);
      cyc();
      m_rvalid = 0; d_req = 1; d_addr = 32'h500;
      cyc();
      m_gnt = 1;
      smp();
      chk("rs_next", {m_req, d_gnt, i_gnt}, 3'b110);
      chk("rs_next_addr", m_addr, 32'h500);
      cyc();
      d_req = 0; m_gnt = 0; m_rvalid = 1; m_rdata = 32'h5A5A;
      smp();
      chk("rs_next_rv", {d_rvalid, d_rdata}, {1'b1, 32'h5A5A});
      cyc();
      m_rvalid = 0;

      // back-to-back loads
      d_req = 1; d_addr = 32'h600;
      cyc();
      m_gnt = 1;
      smp();
      chk("bb_gnt1", d_gnt, 1);
      cyc();
      m_gnt = 0; m_rvalid = 1; m_rdata = 32'h11; d_addr = 32'h604;
      smp();
      chk("bb_rv1", {d_rvalid, d_rdata}, {1'b1, 32'h11});
      cyc();
      m_rvalid = 0; m_gnt = 1;
      smp();
      chk("bb_req2", {m_req, busy, d_gnt}, 3'b111);
      chk("bb_addr2", m_addr, 32'h604);
      cyc();
      d_req = 0; m_gnt = 0; m_rvalid = 1; m_rdata = 32'h22;
      smp();
      chk("bb_rv2", {d_rvalid, d_rdata}, {1'b1, 32'h22});
      cyc();
      m_rvalid = 0;
      smp();
      chk("bb_idle", busy, 0);

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
